match_responder: RTL
====================

# match_responder

Responder end of the match request/response interface driven by each job PE. It accepts one request at a time: head address, history address and a one-hot lazy tag. It compares the bytes at the two addresses in chunks of CMP_BYTES, reading through a fixed-latency dual-read window port. It then returns the extension length with the request tag echoed, and sits between the job PE arbiter and the shared window buffer.

## Interface
Parameters:
- ADDR_WIDTH, `ADDR_WIDTH: byte address width.
- MATCH_LEN_WIDTH, `MATCH_LEN_WIDTH: response length width.
- TAG_WIDTH, `LAZY_MATCH_LEN: tag width; tag is echoed, never interpreted.
- CMP_BYTES, 16: bytes compared per chunk; power of two.
- MAX_MATCH_LEN, 248: length saturation value; must be ≤ 2^MATCH_LEN_WIDTH−1.

Ports:
- clk  in  1  single clock; one clock, all logic on posedge clk.
- rst_n  in  1  reset; asynchronous, active-low.
- match_req_valid  in  1  request valid.
- match_req_head_addr  in  ADDR_WIDTH  current-position byte address.
- match_req_history_addr  in  ADDR_WIDTH  candidate history byte address.
- match_req_tag  in  TAG_WIDTH  opaque tag.
- match_req_ready  out  1  high only in S_IDLE.
- head_limit_addr  in  ADDR_WIDTH  first invalid head byte; sampled with the request.
- rd_en  out  1  window read strobe.
- rd_head_addr  out  ADDR_WIDTH  head chunk address.
- rd_hist_addr  out  ADDR_WIDTH  history chunk address.
- rd_head_data  in  CMP_BYTES*8  head bytes, byte i in [8i+:8]; valid exactly 1 cycle after rd_en.
- rd_hist_data  in  CMP_BYTES*8  history bytes, same layout and timing.
- match_resp_valid  out  1  response valid.
- match_resp_len  out  MATCH_LEN_WIDTH  matched byte count.
- match_resp_tag  out  TAG_WIDTH  echoed tag.
- match_resp_ready  in  1  response accept.

## Operation
- **States:** S_IDLE, S_READ, S_CMP, S_RESP.
- **S_IDLE:**
  - On req_valid&&req_ready, register head, hist, tag and limit; clear len.
  - If hist ≥ head or head ≥ limit, go to S_RESP with len=0 and issue no read.
  - Otherwise go to S_READ.
- **S_READ:** rd_en=1 with rd_head_addr=head and rd_hist_addr=hist; go to S_CMP.
- **S_CMP:**
  - eq[i] = (head byte i == hist byte i).
  - cnt = number of trailing ones of eq, range 0..CMP_BYTES.
  - room = min(CMP_BYTES, MAX_MATCH_LEN−len, limit−head), computed in ADDR_WIDTH+1 bits before narrowing.
  - add = min(cnt, room); len += add.
  - If add==CMP_BYTES and len+add < MAX_MATCH_LEN and head+CMP_BYTES < limit: advance head and hist by CMP_BYTES and go to S_READ.
  - Otherwise go to S_RESP.
- **Overlapping matches:** allowed (hist+k ≥ original head). Bytes are read from the window, which already holds them.
- **S_RESP:** resp_valid=1 with len and tag held stable; on resp_ready go to S_IDLE.
- **Length bound:** len never exceeds MAX_MATCH_LEN or limit−original head.

## Timing
- **Reset values:** state=S_IDLE; match_resp_valid, match_resp_len, match_resp_tag, rd_en, rd_head_addr and rd_hist_addr are 0. match_req_ready=1 once rst_n is high.
- **Reset mid-operation:** the in-flight transaction is dropped and no response is issued. Read data arriving after reset is ignored.
- **Latency, single chunk:** request accepted at cycle T, rd_en at T+1, compare at T+2, resp_valid at T+3.
- **Latency, multi-chunk:** each additional chunk adds 2 cycles.
- **Latency, immediate-zero case:** resp_valid at T+1.
- **No new request while busy:** req_ready=0 from T+1 until the cycle after the response handshake.
- **Back-to-back:** a new request may be accepted the cycle after resp handshake, the earliest being the S_IDLE cycle.
- **Response stall:** resp_valid, once raised, stays high with stable payload until match_resp_ready.
- **Read port:** has no backpressure; rd_en is never asserted outside S_READ.

## Structure
- ADDR_WIDTH, MATCH_LEN_WIDTH and LAZY_MATCH_LEN come from the shared parameters.vh. MAX_MATCH_LEN and CMP_BYTES are added there as `MAX_MATCH_LEN and `MATCH_CMP_BYTES.
- Sub-module match_byte_counter: combinational CMP_BYTES comparator plus trailing-ones count producing cnt[log2(CMP_BYTES):0]. It is reusable by other match units.
- FSM, address advance and saturation arithmetic live in the top module.

## Test plan
- **Single chunk, mismatch at byte 5:** head=1000, hist=200, limit=4000, tag=4'b0010 → rd_en at T+1; resp_len=5, tag=4'b0010 at T+3.
- **Full-chunk run of 40 equal bytes then mismatch:** reads at head 1000, 1016, 1032 → resp_len=40 after 3 chunks, resp_valid at T+7.
- **Saturation on identical data:** MAX_MATCH_LEN=248 → len=248 exactly, last chunk partial (room=8).
- **Limit cap:** head=1000, limit=1010, all bytes equal → len=10, single read. Separately, hist=1000, head=1000 → len=0 at T+1 with no rd_en.
- **Response backpressure:** resp_ready held low 5 cycles → payload stable, req_ready=0 throughout; next request accepted 1 cycle after the handshake.
- **Reset mid-operation:** rst_n low during S_CMP → resp_valid=0, rd_en=0 immediately; after release, req_ready=1 and a fresh request completes normally.

Source files
------------

// File: rtl/match_responder_pkg.sv
// match_responder shared definitions.
// Default widths, limits and FSM state encoding.
package match_responder_pkg;

  localparam int DEF_ADDR_WIDTH      = 16;
  localparam int DEF_MATCH_LEN_WIDTH = 8;
  localparam int DEF_TAG_WIDTH       = 4;
  localparam int DEF_CMP_BYTES       = 16;
  localparam int DEF_MAX_MATCH_LEN   = 248;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_CMP,
    S_RESP
  } state_t;

endpackage

// File: rtl/match_responder_if.sv
// Match request/response channel between a job PE
// (master) and the match responder (slave).
interface match_responder_if
  import match_responder_pkg::*;
#(
  parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int MATCH_LEN_WIDTH = DEF_MATCH_LEN_WIDTH,
  parameter int TAG_WIDTH       = DEF_TAG_WIDTH
);

  logic                       match_req_valid;
  logic [ADDR_WIDTH-1:0]      match_req_head_addr;
  logic [ADDR_WIDTH-1:0]      match_req_history_addr;
  logic [TAG_WIDTH-1:0]       match_req_tag;
  logic                       match_req_ready;
  logic [ADDR_WIDTH-1:0]      head_limit_addr;
  logic                       match_resp_valid;
  logic [MATCH_LEN_WIDTH-1:0] match_resp_len;
  logic [TAG_WIDTH-1:0]       match_resp_tag;
  logic                       match_resp_ready;

  modport master (
    output match_req_valid,
    output match_req_head_addr,
    output match_req_history_addr,
    output match_req_tag,
    output head_limit_addr,
    output match_resp_ready,
    input  match_req_ready,
    input  match_resp_valid,
    input  match_resp_len,
    input  match_resp_tag
  );

  modport slave (
    input  match_req_valid,
    input  match_req_head_addr,
    input  match_req_history_addr,
    input  match_req_tag,
    input  head_limit_addr,
    input  match_resp_ready,
    output match_req_ready,
    output match_resp_valid,
    output match_resp_len,
    output match_resp_tag
  );

endinterface

// File: rtl/match_responder_byte_counter.sv
// Byte-wise chunk comparator: counts the run of equal
// bytes starting at byte 0 (trailing ones of eq).
module match_byte_counter #(
  parameter int CMP_BYTES = 16
) (
  input  logic [CMP_BYTES*8-1:0]     a,
  input  logic [CMP_BYTES*8-1:0]     b,
  output logic [$clog2(CMP_BYTES):0] cnt
);

  localparam int CW = $clog2(CMP_BYTES) + 1;

  logic [CMP_BYTES-1:0] eq;

  // per-byte equality, then lowest mismatching index
  always_comb begin
    cnt = CW'(CMP_BYTES);
    for (int i = 0; i < CMP_BYTES; i++) begin
      eq[i] = (a[8*i+:8] == b[8*i+:8]);
    end
    for (int i = CMP_BYTES - 1; i >= 0; i--) begin
      if (!eq[i]) cnt = CW'(i);
    end
  end

endmodule

// File: rtl/match_responder.sv
// Match responder: compares head vs history bytes chunk
// by chunk via the window read port, returns match length.
module match_responder
  import match_responder_pkg::*;
#(
  parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int MATCH_LEN_WIDTH = DEF_MATCH_LEN_WIDTH,
  parameter int TAG_WIDTH       = DEF_TAG_WIDTH,
  parameter int CMP_BYTES       = DEF_CMP_BYTES,
  parameter int MAX_MATCH_LEN   = DEF_MAX_MATCH_LEN
) (
  input  logic                   clk,
  input  logic                   rst_n,
  match_responder_if.slave       bus,
  output logic                   rd_en,
  output logic [ADDR_WIDTH-1:0]  rd_head_addr,
  output logic [ADDR_WIDTH-1:0]  rd_hist_addr,
  input  logic [CMP_BYTES*8-1:0] rd_head_data,
  input  logic [CMP_BYTES*8-1:0] rd_hist_data
);

  localparam int AW  = ADDR_WIDTH;
  localparam int AW1 = ADDR_WIDTH + 1;
  localparam int LW  = MATCH_LEN_WIDTH;
  localparam int TW  = TAG_WIDTH;
  localparam int CW  = $clog2(CMP_BYTES) + 1;

  state_t          state_q, state_d;
  logic [AW-1:0]   head_q, head_d;
  logic [AW-1:0]   hist_q, hist_d;
  logic [AW-1:0]   limit_q, limit_d;
  logic [TW-1:0]   tag_q, tag_d;
  logic [LW-1:0]   len_q, len_d;

  logic [CW-1:0]   cnt;
  logic [CW-1:0]   add;
  logic [AW1-1:0]  room;
  logic [AW1-1:0]  room_max;
  logic [AW1-1:0]  room_lim;
  logic [AW1-1:0]  head_end;
  logic [LW-1:0]   len_nx;
  logic            more;
  logic            zero;

  match_byte_counter #(
    .CMP_BYTES (CMP_BYTES)
  ) u_cnt (
    .a   (rd_head_data),
    .b   (rd_hist_data),
    .cnt (cnt)
  );

  // chunk credit: clamp run length by chunk, length cap and limit
  always_comb begin
    room_max = AW1'(MAX_MATCH_LEN) - AW1'(len_q);
    room_lim = {1'b0, limit_q} - {1'b0, head_q};
    room     = AW1'(CMP_BYTES);
    if (room_max < room) room = room_max;
    if (room_lim < room) room = room_lim;
    if (AW1'(cnt) < room) add = cnt;
    else                  add = CW'(room);
    len_nx   = len_q + LW'(add);
    head_end = {1'b0, head_q} + AW1'(CMP_BYTES);
    more     = (add == CW'(CMP_BYTES))
            && (len_nx < LW'(MAX_MATCH_LEN))
            && (head_end < {1'b0, limit_q});
    zero     = (bus.match_req_history_addr >= bus.match_req_head_addr)
            || (bus.match_req_head_addr >= bus.head_limit_addr);
  end

  // next state and datapath updates
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    hist_d  = hist_q;
    limit_d = limit_q;
    tag_d   = tag_q;
    len_d   = len_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.match_req_valid) begin
          head_d  = bus.match_req_head_addr;
          hist_d  = bus.match_req_history_addr;
          limit_d = bus.head_limit_addr;
          tag_d   = bus.match_req_tag;
          len_d   = '0;
          state_d = zero ? S_RESP : S_READ;
        end
      end
      S_READ: begin
        state_d = S_CMP;
      end
      S_CMP: begin
        len_d = len_nx;
        if (more) begin
          head_d  = head_q + AW'(CMP_BYTES);
          hist_d  = hist_q + AW'(CMP_BYTES);
          state_d = S_READ;
        end else begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.match_resp_ready) state_d = S_IDLE;
      end
    endcase
  end

  // state and transaction registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      head_q  <= '0;
      hist_q  <= '0;
      limit_q <= '0;
      tag_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      hist_q  <= hist_d;
      limit_q <= limit_d;
      tag_q   <= tag_d;
      len_q   <= len_d;
    end
  end

  assign rd_en                = (state_q == S_READ);
  assign rd_head_addr         = head_q;
  assign rd_hist_addr         = hist_q;
  assign bus.match_req_ready  = (state_q == S_IDLE);
  assign bus.match_resp_valid = (state_q == S_RESP);
  assign bus.match_resp_len   = len_q;
  assign bus.match_resp_tag   = tag_q;

endmodule
